result_display_sequencer: RTL

- Sequences readout of the 32-entry CPU result memory onto the board's 4-digit multiplexed 7-segment display.
- Debounces the step buttons and maintains the read address.
- Fetches each word through a 1-cycle-latency read port and converts it to BCD with a sequential double-dabble, so the datapath has no combinational dividers.
- Scans the four digits and sits between the result memory and the seg/anode pins.

---
 rtl/result_display_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/result_display_sequencer.sv
// Steps through the 32-word result memory and shows each word in decimal on the
// 4-digit multiplexed 7-segment display, converting with a sequential double-dabble.

module rds_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Counter runs only while the synced level differs from the accepted one,
    // so any bounce back to the old level restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= sync_q[1];
                press_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;
endmodule

module result_display_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned SCAN_CYCLES     = 500000,
    parameter int unsigned AUTO_CYCLES     = 100000000,
    parameter int unsigned ADDR_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_auto,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              auto_en,
    output logic              busy
);
    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam int unsigned B_NEXT = 0, B_PREV = 1, B_AUTO = 2;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_CONV, S_LOAD} state_e;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'b1000000;
            4'd1:    seg_lut = 7'b1111001;
            4'd2:    seg_lut = 7'b0100100;
            4'd3:    seg_lut = 7'b0110000;
            4'd4:    seg_lut = 7'b0011001;
            4'd5:    seg_lut = 7'b0010010;
            4'd6:    seg_lut = 7'b0000010;
            4'd7:    seg_lut = 7'b1111000;
            4'd8:    seg_lut = 7'b0000000;
            4'd9:    seg_lut = 7'b0010000;
            default: seg_lut = 7'b1111111;
        endcase
    endfunction

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}.
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            if (t[14+4*k +: 4] >= 4'd5) t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
        end
        dd_step = {t[28:0], 1'b0};
    endfunction

    logic [2:0] btn_raw, press;
    assign btn_raw = {btn_auto, btn_prev, btn_next};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        rds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn_raw[i]),
            .press_o(press[i])
        );
    end

    logic [AW-1:0] atmr_q;
    logic          auto_en_q;
    logic          auto_p;

    assign auto_p = auto_en_q && (atmr_q == AW'(AUTO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atmr_q    <= '0;
            auto_en_q <= 1'b0;
        end else begin
            auto_en_q <= auto_en_q ^ press[B_AUTO];
            if (|press)           atmr_q <= '0;
            else if (auto_p)      atmr_q <= '0;
            else if (auto_en_q)   atmr_q <= atmr_q + AW'(1);
        end
    end

    // Coincident next and prev cancel; the auto tick counts as a next.
    logic step_vld, step_dir;
    assign step_vld = (press[B_NEXT] | auto_p) ^ press[B_PREV];
    assign step_dir = press[B_NEXT] | auto_p;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic               pend_vld_q, pend_vld_d, pend_dir_q, pend_dir_d;
    logic               start_q, start_d;
    logic               ovf_q, ovf_d, dov_q, dov_d;
    logic [29:0]        sh_q, sh_d;
    logic [3:0]         it_q, it_d;
    logic [3:0][3:0]    dig_q, dig_d;
    logic [SW-1:0]      scan_q, scan_d;
    logic [1:0]         level_q, level_d;
    logic [6:0]         seg_q, seg_d;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        start_d    = start_q;
        ovf_d      = ovf_q;
        sh_d       = sh_q;
        it_d       = it_q;
        dig_d      = dig_q;
        dov_d      = dov_q;
        rd_en      = 1'b0;
        busy       = 1'b0;

        if (state_q != S_IDLE && step_vld && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_dir_d = step_dir;
        end

        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    start_d = 1'b0;
                    state_d = S_FETCH;
                end else if (pend_vld_q) begin
                    cur_d      = pend_dir_q ? cur_q + ADDR_W'(1) : cur_q - ADDR_W'(1);
                    pend_vld_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (step_vld) begin
                    cur_d   = step_dir ? cur_q + ADDR_W'(1) : cur_q - ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                busy    = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy    = 1'b1;
                ovf_d   = (rd_data > 32'd9999);
                sh_d    = {16'd0, rd_data[13:0]};
                it_d    = 4'd0;
                state_d = S_CONV;
            end
            S_CONV: begin
                busy = 1'b1;
                sh_d = dd_step(sh_q);
                it_d = it_q + 4'd1;
                if (it_q == 4'd13) state_d = S_LOAD;
            end
            S_LOAD: begin
                dig_d   = sh_q[29:14];
                dov_d   = ovf_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Segment register is fed from next-state level/digits so seg always
    // matches the anode currently driven.
    always_comb begin
        scan_d  = scan_q + SW'(1);
        level_d = level_q;
        if (scan_q == SW'(SCAN_CYCLES - 1)) begin
            scan_d  = '0;
            level_d = level_q + 2'd1;
        end
        seg_d = dov_d ? SEG_DASH : seg_lut(dig_d[2'd3 - level_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= 1'b0;
            start_q    <= 1'b1;
            ovf_q      <= 1'b0;
            dov_q      <= 1'b0;
            sh_q       <= '0;
            it_q       <= '0;
            dig_q      <= '0;
            scan_q     <= '0;
            level_q    <= '0;
            seg_q      <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            start_q    <= start_d;
            ovf_q      <= ovf_d;
            dov_q      <= dov_d;
            sh_q       <= sh_d;
            it_q       <= it_d;
            dig_q      <= dig_d;
            scan_q     <= scan_d;
            level_q    <= level_d;
            seg_q      <= seg_d;
        end
    end

    always_comb begin
        case (level_q)
            2'd0:    an = 4'b0111;
            2'd1:    an = 4'b1011;
            2'd2:    an = 4'b1101;
            default: an = 4'b1110;
        endcase
    end

    assign seg      = seg_q;
    assign rd_addr  = cur_q;
    assign cur_addr = cur_q;
    assign auto_en  = auto_en_q;
endmodule
